// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared state type, read-during-write constants and byte-merge helper
package memory_pkg;

  typedef enum logic {INIT, READY} state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest word the merge helper handles; callers widen their operands and truncate the result.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/memory_rd_pipe.sv
// rtl/memory_rd_pipe.sv - delay line of {valid, data} stages between the array read and Data_out
module memory_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int STAGES = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ RST;
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_stages
      logic [STAGES-1:0] v;
      logic [DATA_W-1:0] d [STAGES];

      always_ff @(posedge CLK) begin
        if (RST) begin
          v <= '0;
          for (int i = 0; i < STAGES; i++) d[i] <= '0;
        end else begin
          v[0] <= in_valid;
          d[0] <= in_data;
          for (int i = 1; i < STAGES; i++) begin
            v[i] <= v[i-1];
            d[i] <= d[i-1];
          end
        end
      end

      assign out_valid = v[STAGES-1];
      assign out_data  = d[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/memory_param.sv
// rtl/memory_param.sv - parametrised synchronous RAM with byte enables, pipelined reads
// and an optional post-reset clear window signalled by Busy
module memory_param
  import memory_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int RD_LAT         = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W-1:0]   Data_in,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic [DATA_W-1:0]   Data_out,
  output logic                Data_valid,
  output logic                Busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] init_cnt;

  logic              rd_req;
  logic              wr_req;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] rd_word;

  logic              st0_valid;
  logic [DATA_W-1:0] st0_data;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;

  assign rd_req      = (state == READY) && MemRead;
  assign wr_req      = (state == READY) && MemWrite && (|ByteEn);
  assign old_word    = mem[ADDR];
  assign merged_word = DATA_W'(be_merge(MAX_DATA_W'(old_word), MAX_DATA_W'(Data_in),
                                        MAX_BE_W'(ByteEn)));

  // Read and write share ADDR, so a same-cycle write always targets the word being read.
  always_comb begin
    rd_word = old_word;
    case (RDW_MODE)
      RDW_OLD: rd_word = old_word;
      RDW_NEW: if (wr_req) rd_word = merged_word;
      default: rd_word = old_word;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if ((state == INIT) && (CLEAR_ON_RESET != 0)) mem[init_cnt] <= '0;
      else if (wr_req)                               mem[ADDR] <= merged_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= INIT;
      init_cnt <= '0;
      Busy     <= 1'b1;
    end else if (state == INIT) begin
      if ((CLEAR_ON_RESET == 0) || (init_cnt == LAST_ADDR)) begin
        state <= READY;
        Busy  <= 1'b0;
      end else begin
        init_cnt <= init_cnt + ADDR_W'(1);
      end
    end
  end

  // The word is captured on the request edge so later writes cannot disturb an in-flight read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st0_valid <= 1'b0;
      st0_data  <= '0;
    end else begin
      st0_valid <= rd_req;
      if (rd_req) st0_data <= rd_word;
    end
  end

  memory_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT - 1)
  ) u_rd_pipe (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (st0_valid),
    .in_data   (st0_data),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      Data_valid <= 1'b0;
      Data_out   <= '0;
    end else begin
      Data_valid <= pipe_valid;
      if (pipe_valid) Data_out <= pipe_data;
    end
  end

endmodule

// File: tb/tb_memory_param.sv
// tb/tb_memory_param.sv - three memory_param configurations on shared stimulus,
// compared every cycle against a per-configuration reference model
module tb_memory_param;

  localparam int NDUT = 3;
  localparam int LAT  [NDUT] = '{1, 3, 2};
  localparam int RDWM [NDUT] = '{0, 1, 0};
  localparam int CLR  [NDUT] = '{1, 1, 0};

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemRead;
  logic        MemWrite;
  logic [7:0]  ADDR;
  logic [15:0] Data_in;
  logic [1:0]  ByteEn;
  logic [15:0] dout [NDUT];
  logic        dval [NDUT];
  logic        busy [NDUT];

  always #5 CLK = ~CLK;

  memory_param #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .ADDR(ADDR), .Data_in(Data_in),
    .ByteEn(ByteEn), .Data_out(dout[0]), .Data_valid(dval[0]), .Busy(busy[0]));

  memory_param #(.DATA_W(16), .ADDR_W(8), .RD_LAT(3), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .ADDR(ADDR), .Data_in(Data_in),
    .ByteEn(ByteEn), .Data_out(dout[1]), .Data_valid(dval[1]), .Busy(busy[1]));

  memory_param #(.DATA_W(16), .ADDR_W(8), .RD_LAT(2), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut_c (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .ADDR(ADDR), .Data_in(Data_in),
    .ByteEn(ByteEn), .Data_out(dout[2]), .Data_valid(dval[2]), .Busy(busy[2]));

  // Reference state: contents plus a known flag (dut_c is never cleared), cycles of Busy left,
  // and read results keyed by (edge number * 4 + dut index) at which they must appear.
  logic [15:0] mmem [NDUT][256];
  bit          kmem [NDUT][256];
  int          busy_left [NDUT];
  logic [15:0] last_dout [NDUT];
  bit          last_known [NDUT];
  logic [16:0] due [int];

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;
  int bcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input int a, input logic [15:0] d,
                       input logic [1:0] be);
    MemRead  = rd;
    MemWrite = wr;
    ADDR     = 8'(a);
    Data_in  = d;
    ByteEn   = be;
  endtask

  task automatic idle();
    drive(0, 0, 0, 16'h0000, 2'b00);
  endtask

  task automatic tick();
    int          e;
    int          key;
    bit          ev;
    bit          ko;
    bit          kr;
    logic [15:0] old_w;
    logic [15:0] mrg;
    logic [15:0] rv;
    e = cyc + 1;
    if (RST) begin
      due.delete();
      for (int k = 0; k < NDUT; k++) begin
        busy_left[k]  = (CLR[k] != 0) ? 256 : 1;
        last_dout[k]  = 16'h0000;
        last_known[k] = 1'b1;
      end
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        if (busy_left[k] > 0) begin
          if (CLR[k] != 0) begin
            mmem[k][256 - busy_left[k]] = 16'h0000;
            kmem[k][256 - busy_left[k]] = 1'b1;
          end
          busy_left[k]--;
        end else begin
          old_w = mmem[k][ADDR];
          ko    = kmem[k][ADDR];
          mrg   = old_w;
          for (int b = 0; b < 2; b++) if (ByteEn[b]) mrg[8*b +: 8] = Data_in[8*b +: 8];
          if (MemRead) begin
            rv = old_w;
            kr = ko;
            if (MemWrite && RDWM[k] == 1) begin
              rv = mrg;
              kr = ko || (ByteEn == 2'b11);
            end
            due[(e + LAT[k]) * 4 + k] = {kr, rv};
          end
          if (MemWrite) begin
            mmem[k][ADDR] = mrg;
            kmem[k][ADDR] = ko || (ByteEn == 2'b11);
          end
        end
      end
    end
    @(posedge CLK);
    #1;
    cyc = e;
    for (int k = 0; k < NDUT; k++) begin
      key = cyc * 4 + k;
      ev  = due.exists(key);
      if (ev) begin
        {last_known[k], last_dout[k]} = due[key];
        due.delete(key);
      end
      check($sformatf("busy%0d", k), 32'(busy[k]), 32'(busy_left[k] > 0));
      check($sformatf("valid%0d", k), 32'(dval[k]), 32'(ev));
      if (last_known[k]) check($sformatf("dout%0d", k), 32'(dout[k]), 32'(last_dout[k]));
    end
  endtask

  task automatic run_idle(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++)
      for (int a = 0; a < 256; a++) begin
        mmem[k][a] = 16'h0000;
        kmem[k][a] = 1'b0;
      end
    idle();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // Clear window; a write issued while dut_a/dut_b are busy must be dropped by them.
    bcnt = 0;
    for (int i = 0; i < 400 && busy[0]; i++) begin
      if (i == 10) drive(0, 1, 'h05, 16'hFFFF, 2'b11);
      else idle();
      tick();
      bcnt++;
    end
    check("busy_len", 32'(bcnt), 32'd256);

    drive(1, 0, 'h7F, 16'h0000, 2'b00); tick();
    drive(1, 0, 'h05, 16'h0000, 2'b00); tick();
    run_idle(5);
    check("ignored_wr", 32'(dout[0]), 32'h0000);

    drive(0, 1, 'h10, 16'hAABB, 2'b11); tick();
    drive(0, 1, 'h10, 16'h00CC, 2'b01); tick();
    drive(1, 0, 'h10, 16'h0000, 2'b00); tick();
    run_idle(5);
    check("be_merge", 32'(dout[0]), 32'hAACC);

    drive(0, 1, 'h20, 16'h1234, 2'b11); tick();
    drive(1, 1, 'h20, 16'h5678, 2'b11); tick();
    drive(1, 0, 'h20, 16'h0000, 2'b00); tick();
    run_idle(5);

    drive(0, 1, 'h01, 16'h0101, 2'b11); tick();
    drive(0, 1, 'h02, 16'h0202, 2'b11); tick();
    drive(0, 1, 'h03, 16'h0303, 2'b11); tick();
    drive(1, 0, 'h01, 16'h0000, 2'b00); tick();
    drive(1, 0, 'h02, 16'h0000, 2'b00); tick();
    drive(1, 0, 'h03, 16'h0000, 2'b00); tick();
    run_idle(5);
    check("lat3_last", 32'(dout[1]), 32'h0303);

    // Two reads in flight when reset lands: none of them may surface.
    drive(1, 0, 'h01, 16'h0000, 2'b00); tick();
    drive(1, 0, 'h02, 16'h0000, 2'b00); tick();
    idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    run_idle(100);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 400 && busy[0]; i++) begin
      tick();
      bcnt++;
    end
    check("busy_restart", 32'(bcnt), 32'd256);
    check("busy_b_done", 32'(busy[1]), 32'd0);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50), $urandom_range(0, 15),
            16'($urandom), 2'($urandom_range(0, 3)));
      tick();
    end
    run_idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
